softmax_argmax_collector: RTL and testbench
===========================================

SOFTMAX_ARGMAX_COLLECTOR -- requirements
Module: softmax_argmax_collector

Interface
REQ-001 SHALL have parameter bitWidth, default 16: width of each signed softmax score.
REQ-002 SHALL have parameter outputSize, default 10: number of class scores per frame.
REQ-003 SHALL have parameter idxWidth, default 4: class index width; outputSize <= 2**idxWidth.
REQ-004 SHALL have parameter cntWidth, default 16: classified-frame counter width.
REQ-005 SHALL have port clk_p  input  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port frameDone  input  1: one-cycle pulse; scoresIn holds a complete frame result this cycle.
REQ-008 SHALL have port scoresIn  input  signed [bitWidth-1:0] x outputSize: softmax outputs, element 0 = class 0.
REQ-009 SHALL have port classReady  input  1: consumer accepts the result.
REQ-010 SHALL have port classValid  output  1: classIdx/classScore hold a valid result.
REQ-011 SHALL have port classIdx  output  idxWidth: index of the maximum score.
REQ-012 SHALL have port classScore  output  signed bitWidth: maximum score value.
REQ-013 SHALL have port busy  output  1: high in SCAN or VALID.
REQ-014 SHALL have port overflow  output  1: sticky; a frameDone was dropped.
REQ-015 SHALL have port frameCount  output  cntWidth: number of results accepted by the consumer.

Function
REQ-016 SHALL implement states IDLE, SCAN, VALID; reset state IDLE.
REQ-017 IDLE: frameDone=1 at an edge SHALL copy all outputSize scores into an internal bank, load best=scoresIn[0], bestIdx=0, scan index i=1, and go to SCAN.
REQ-018 SCAN: each edge SHALL compare bank[i] against best as signed values; best/bestIdx update only if bank[i] > best (strict), so ties resolve to the lowest index.
REQ-019 SCAN SHALL process exactly one element per cycle; on the edge processing i=outputSize-1, go to VALID.
REQ-020 Latency SHALL be outputSize-1 cycles from the capture edge to classValid=1 (9 cycles for the defaults); if outputSize=1, go directly from IDLE to VALID on the capture edge.
REQ-021 VALID: classValid=1; classIdx=bestIdx; classScore=best; outputs held stable until handshake.
REQ-022 VALID with classReady=1 at an edge SHALL complete the handshake: frameCount increments (wraps at 2**cntWidth to 0), and state goes to IDLE.
REQ-023 VALID with classReady=1 and frameDone=1 at the same edge SHALL complete the handshake and capture the new frame (go to SCAN), with no frame lost and no overflow.
REQ-024 frameDone=1 in SCAN, or in VALID with classReady=0, SHALL be ignored for capture and SHALL set overflow=1; the bank and the scan are unaffected.
REQ-025 overflow SHALL clear only on reset.
REQ-026 busy SHALL be 1 exactly when the state is SCAN or VALID.
REQ-027 classReady while not in VALID SHALL have no effect.
REQ-028 classIdx and classScore SHALL be 0 whenever classValid=0.
REQ-029 Comparisons SHALL use full bitWidth signed arithmetic with no truncation or saturation.

Reset
REQ-030 reset=0 SHALL immediately, independent of clk_p, force: state IDLE, classValid=0, classIdx=0, classScore=0, busy=0, overflow=0, frameCount=0, bank=0.
REQ-031 reset asserted mid-SCAN or mid-VALID SHALL abort the frame with no result produced.
REQ-032 After release, the first frameDone sampled on a rising edge SHALL be captured normally.

Verification
REQ-033 Scores {100,200,50,900,10,0,-5,300,899,1} with frameDone pulse and classReady=1 -> classValid rises 9 cycles after the capture edge, classIdx=3, classScore=900, frameCount=1.
REQ-034 Tie: scores[2]=scores[7]=1024, all others 0 -> classIdx=2, classScore=1024.
REQ-035 All negative: {-1,-2,...,-10} -> classIdx=0, classScore=-1; the signed comparison is verified.
REQ-036 classReady=0 for 20 cycles in VALID, with a second frameDone at cycle 5 -> outputs stable, overflow=1, first result unchanged; after classReady, frameCount=1 and state is IDLE.
REQ-037 Back-to-back: frameDone and classReady both high in the same VALID cycle -> new frame captured, overflow stays 0, second result correct, frameCount=2.
REQ-038 reset=0 asserted 4 cycles into SCAN -> all outputs 0 asynchronously; no classValid after release until a new frameDone.

Source files
------------

// File: rtl/softmax_argmax_collector.sv
// Collects one frame of signed softmax scores and reports the index and value of the
// largest score through a valid/ready handshake, scanning one element per clock.
module softmax_argmax_collector #(
  parameter int bitWidth   = 16,
  parameter int outputSize = 10,
  parameter int idxWidth   = 4,
  parameter int cntWidth   = 16
) (
  input  logic                       clk_p,
  input  logic                       reset,
  input  logic                       frameDone,
  input  logic signed [bitWidth-1:0] scoresIn [0:outputSize-1],
  input  logic                       classReady,
  output logic                       classValid,
  output logic        [idxWidth-1:0] classIdx,
  output logic signed [bitWidth-1:0] classScore,
  output logic                       busy,
  output logic                       overflow,
  output logic        [cntWidth-1:0] frameCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(outputSize - 1);
  localparam logic [idxWidth-1:0] FIRST_SCAN_IDX = idxWidth'(1);

  state_t                       state_q;
  logic signed [bitWidth-1:0]   bank_q [0:outputSize-1];
  logic signed [bitWidth-1:0]   best_q;
  logic        [idxWidth-1:0]   bestIdx_q;
  logic        [idxWidth-1:0]   i_q;
  logic                         classValid_q;
  logic        [idxWidth-1:0]   classIdx_q;
  logic signed [bitWidth-1:0]   classScore_q;
  logic                         busy_q;
  logic                         overflow_q;
  logic        [cntWidth-1:0]   frameCount_q;

  logic signed [bitWidth-1:0]   best_d;
  logic        [idxWidth-1:0]   bestIdx_d;
  logic                         capture_d;
  logic                         drop_d;
  logic                         handshake_d;

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
    best_d    = best_q;
    bestIdx_d = bestIdx_q;
    if (bank_q[i_q] > best_q) begin
      best_d    = bank_q[i_q];
      bestIdx_d = i_q;
    end
  end

  always_comb begin
    handshake_d = (state_q == VALID) && classReady;
    capture_d   = frameDone && ((state_q == IDLE) || handshake_d);
    drop_d      = frameDone && !capture_d;
  end

  always_ff @(posedge clk_p or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      for (int k = 0; k < outputSize; k++) bank_q[k] <= '0;
      best_q       <= '0;
      bestIdx_q    <= '0;
      i_q          <= '0;
      classValid_q <= 1'b0;
      classIdx_q   <= '0;
      classScore_q <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      frameCount_q <= '0;
    end else begin
      if (drop_d) overflow_q <= 1'b1;

      unique case (state_q)
        SCAN: begin
          best_q    <= best_d;
          bestIdx_q <= bestIdx_d;
          i_q       <= i_q + FIRST_SCAN_IDX;
          if (i_q == LAST_IDX) begin
            state_q      <= VALID;
            i_q          <= '0;
            classValid_q <= 1'b1;
            classIdx_q   <= bestIdx_d;
            classScore_q <= best_d;
          end
        end
        VALID: begin
          if (classReady) begin
            frameCount_q <= frameCount_q + cntWidth'(1);
            state_q      <= IDLE;
            classValid_q <= 1'b0;
            classIdx_q   <= '0;
            classScore_q <= '0;
            busy_q       <= 1'b0;
          end
        end
        default: ;
      endcase

      // A capture overrides the idle/return-to-idle assignments above.
      if (capture_d) begin
        bank_q    <= scoresIn;
        best_q    <= scoresIn[0];
        bestIdx_q <= '0;
        busy_q    <= 1'b1;
        if (outputSize == 1) begin
          state_q      <= VALID;
          i_q          <= '0;
          classValid_q <= 1'b1;
          classIdx_q   <= '0;
          classScore_q <= scoresIn[0];
        end else begin
          state_q      <= SCAN;
          i_q          <= FIRST_SCAN_IDX;
          classValid_q <= 1'b0;
          classIdx_q   <= '0;
          classScore_q <= '0;
        end
      end
    end
  end

  assign classValid = classValid_q;
  assign classIdx   = classIdx_q;
  assign classScore = classScore_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign frameCount = frameCount_q;

endmodule

// File: tb/tb_softmax_argmax_collector.sv
// Directed bench for softmax_argmax_collector: argmax, ties, signed values, stall,
// back-to-back handshake and asynchronous reset mid-scan.
module tb_softmax_argmax_collector;

  localparam int BW = 16;
  localparam int NS = 10;
  localparam int IW = 4;
  localparam int CW = 16;

  logic                 clk_p;
  logic                 reset;
  logic                 frameDone;
  logic signed [BW-1:0] scores [0:NS-1];
  logic                 classReady;
  logic                 classValid;
  logic        [IW-1:0] classIdx;
  logic signed [BW-1:0] classScore;
  logic                 busy;
  logic                 overflow;
  logic        [CW-1:0] frameCount;

  int tests;
  int failed;

  softmax_argmax_collector #(
    .bitWidth(BW), .outputSize(NS), .idxWidth(IW), .cntWidth(CW)
  ) dut (
    .clk_p(clk_p),
    .reset(reset),
    .frameDone(frameDone),
    .scoresIn(scores),
    .classReady(classReady),
    .classValid(classValid),
    .classIdx(classIdx),
    .classScore(classScore),
    .busy(busy),
    .overflow(overflow),
    .frameCount(frameCount)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Presents the current scores with a one-cycle frameDone pulse; returns on the
  // falling edge right after the capture edge.
  task automatic send_frame();
    @(negedge clk_p);
    frameDone = 1'b1;
    @(negedge clk_p);
    frameDone = 1'b0;
  endtask

  // From the falling edge after capture: 8 edges still scanning, the 9th shows valid.
  task automatic wait_result(input string tag);
    repeat (8) @(negedge clk_p);
    check({tag, "_prevalid"}, 32'(classValid), 32'd0);
    check({tag, "_busy_scan"}, 32'(busy), 32'd1);
    @(negedge clk_p);
    check({tag, "_valid"}, 32'(classValid), 32'd1);
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    reset      = 1'b0;
    frameDone  = 1'b0;
    classReady = 1'b0;
    scores     = '{default: '0};

    repeat (3) @(negedge clk_p);
    check("rst_valid", 32'(classValid), 32'd0);
    check("rst_idx", 32'(classIdx), 32'd0);
    check("rst_score", 32'(classScore), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(frameCount), 32'd0);
    reset = 1'b1;

    // Basic argmax with consumer always ready.
    classReady = 1'b1;
    scores = '{100, 200, 50, 900, 10, 0, -5, 300, 899, 1};
    send_frame();
    wait_result("basic");
    check("basic_idx", 32'(classIdx), 32'd3);
    check("basic_score", 32'(classScore), 32'd900);
    @(negedge clk_p);
    check("basic_cnt", 32'(frameCount), 32'd1);
    check("basic_valid_low", 32'(classValid), 32'd0);
    check("basic_idx_zero", 32'(classIdx), 32'd0);
    check("basic_score_zero", 32'(classScore), 32'd0);
    check("basic_idle", 32'(busy), 32'd0);
    classReady = 1'b0;

    // Tie goes to the lower index.
    scores = '{0, 0, 1024, 0, 0, 0, 0, 1024, 0, 0};
    send_frame();
    wait_result("tie");
    check("tie_idx", 32'(classIdx), 32'd2);
    check("tie_score", 32'(classScore), 32'd1024);
    classReady = 1'b1;
    @(negedge clk_p);
    classReady = 1'b0;
    check("tie_cnt", 32'(frameCount), 32'd2);

    // All negative values exercise the signed compare.
    scores = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    send_frame();
    wait_result("neg");
    check("neg_idx", 32'(classIdx), 32'd0);
    check("neg_score", 32'(classScore), -32'sd1);
    classReady = 1'b1;
    @(negedge clk_p);
    classReady = 1'b0;
    check("neg_cnt", 32'(frameCount), 32'd3);

    // Stall in VALID with a dropped frame in the middle.
    scores = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -100};
    send_frame();
    wait_result("stall");
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        scores = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1000};
        frameDone = 1'b1;
      end else begin
        frameDone = 1'b0;
      end
      @(negedge clk_p);
      check("stall_valid", 32'(classValid), 32'd1);
      check("stall_idx", 32'(classIdx), 32'd8);
      check("stall_score", 32'(classScore), 32'd90);
    end
    frameDone = 1'b0;
    check("stall_ovf", 32'(overflow), 32'd1);
    check("stall_cnt_held", 32'(frameCount), 32'd3);
    classReady = 1'b1;
    @(negedge clk_p);
    classReady = 1'b0;
    check("stall_cnt", 32'(frameCount), 32'd4);
    check("stall_idle", 32'(busy), 32'd0);
    check("stall_ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset four cycles into a scan.
    scores = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame();
    repeat (3) @(negedge clk_p);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(classValid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_cnt", 32'(frameCount), 32'd0);
    check("arst_score", 32'(classScore), 32'd0);
    @(negedge clk_p);
    reset = 1'b1;
    repeat (15) @(negedge clk_p);
    check("arst_no_result", 32'(classValid), 32'd0);
    check("arst_still_idle", 32'(busy), 32'd0);

    // Back-to-back: new frame captured on the handshake edge.
    scores = '{100, 200, 50, 900, 10, 0, -5, 300, 899, 1};
    send_frame();
    wait_result("b2b_a");
    check("b2b_a_idx", 32'(classIdx), 32'd3);
    scores = '{-32768, 0, 0, 0, 32767, 0, 0, 0, 0, 0};
    frameDone  = 1'b1;
    classReady = 1'b1;
    @(negedge clk_p);
    frameDone  = 1'b0;
    classReady = 1'b0;
    check("b2b_cnt1", 32'(frameCount), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_ovf", 32'(overflow), 32'd0);
    wait_result("b2b_b");
    check("b2b_b_idx", 32'(classIdx), 32'd4);
    check("b2b_b_score", 32'(classScore), 32'd32767);
    classReady = 1'b1;
    @(negedge clk_p);
    classReady = 1'b0;
    check("b2b_cnt2", 32'(frameCount), 32'd2);
    check("b2b_ovf_end", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
